// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam logic [1:0]  WIN_SEL_DEF = 2'b10;
  localparam int unsigned ADR_W_DEF   = 14;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; on a tie the port not granted last time wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic       o_grant
);

  logic r_last_grant;

  always_comb begin
    if (i_req == 2'b11) begin
      o_grant = ~r_last_grant;
    end else if (i_req[REQ_DBG]) begin
      o_grant = REQ_DBG;
    end else begin
      o_grant = REQ_CPU;
    end
  end

  // Resets to DBG so the CPU wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= REQ_DBG;
    end else if (i_advance) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between the CPU and debug ports:
// IDLE latches the winner, ACCESS drives the RAM, RESP returns a one-cycle ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [1:0]  WIN_SEL = WIN_SEL_DEF,
  parameter int unsigned ADR_W   = ADR_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cpu_valid,
  input  logic [31:0]      i_cpu_addr,
  input  logic [31:0]      i_cpu_wdata,
  input  logic [3:0]       i_cpu_wstrb,
  output logic [31:0]      o_cpu_rdata,
  output logic             o_cpu_ready,
  input  logic             i_dbg_valid,
  input  logic [31:0]      i_dbg_addr,
  input  logic [31:0]      i_dbg_wdata,
  input  logic [3:0]       i_dbg_wstrb,
  output logic [31:0]      o_dbg_rdata,
  output logic             o_dbg_ready,
  output logic             o_ram_cs,
  output logic [3:0]       o_ram_wren,
  output logic [ADR_W-1:0] o_ram_adr,
  output logic [31:0]      o_ram_di,
  input  logic [31:0]      i_ram_do,
  output logic             o_decode_err
);

  state_e           r_state, w_state_next;
  logic             r_gnt, r_hit;
  logic [ADR_W-1:0] r_adr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;

  logic        w_any, w_advance, w_gnt, w_cs, w_resp, w_unused_addr;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic [3:0]  w_wstrb;

  assign w_any     = i_cpu_valid | i_dbg_valid;
  assign w_advance = (r_state == IDLE) && w_any;

  rr_arbiter2 u_rr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     ({i_dbg_valid, i_cpu_valid}),
    .i_advance (w_advance),
    .o_grant   (w_gnt)
  );

  always_comb begin
    w_addr  = i_cpu_addr;
    w_wdata = i_cpu_wdata;
    w_wstrb = i_cpu_wstrb;
    if (w_gnt == REQ_DBG) begin
      w_addr  = i_dbg_addr;
      w_wdata = i_dbg_wdata;
      w_wstrb = i_dbg_wstrb;
    end
  end

  // Only the window bits and the word address matter; the rest alias.
  assign w_unused_addr = ^w_addr;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_next = ACCESS;
      ACCESS:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_gnt   <= REQ_CPU;
      r_hit   <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_advance) begin
        r_gnt   <= w_gnt;
        r_hit   <= (w_addr[17:16] == WIN_SEL);
        r_adr   <= w_addr[ADR_W+1:2];
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
      end
    end
  end

  assign w_cs   = (r_state == ACCESS) && r_hit;
  assign w_resp = (r_state == RESP);

  // ram_do is valid in RESP because cs was sampled at the ACCESS->RESP edge.
  assign w_rdata = r_hit ? i_ram_do : 32'h0;

  always_comb begin
    o_ram_cs     = w_cs;
    o_ram_wren   = w_cs ? r_wstrb : 4'h0;
    o_ram_adr    = r_adr;
    o_ram_di     = r_wdata;
    o_cpu_ready  = w_resp && (r_gnt == REQ_CPU);
    o_dbg_ready  = w_resp && (r_gnt == REQ_DBG);
    o_cpu_rdata  = o_cpu_ready ? w_rdata : 32'h0;
    o_dbg_rdata  = o_dbg_ready ? w_rdata : 32'h0;
    o_decode_err = w_resp && !r_hit;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-slot reference model checked every
// cycle, and directed transfers with literal expectations.
module tb_mem_arbiter;

  localparam int NP = 4096;

  logic        clk;
  logic        rst;
  logic        cpu_valid, dbg_valid, cpu_ready, dbg_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  cpu_wstrb, dbg_wstrb, ram_wren;
  logic        ram_cs, decode_err;
  logic [13:0] ram_adr;
  logic [31:0] ram_di, ram_do;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_valid  (cpu_valid),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_wstrb  (cpu_wstrb),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_ready  (cpu_ready),
    .i_dbg_valid  (dbg_valid),
    .i_dbg_addr   (dbg_addr),
    .i_dbg_wdata  (dbg_wdata),
    .i_dbg_wstrb  (dbg_wstrb),
    .o_dbg_rdata  (dbg_rdata),
    .o_dbg_ready  (dbg_ready),
    .o_ram_cs     (ram_cs),
    .o_ram_wren   (ram_wren),
    .o_ram_adr    (ram_adr),
    .o_ram_di     (ram_di),
    .i_ram_do     (ram_do),
    .o_decode_err (decode_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ram16Kx32: one-cycle synchronous read, byte-enabled write.
  logic [31:0] mem [16384];
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    ram_do <= 32'h0;
    forever begin
      @(posedge clk);
      if (ram_cs) begin
        ram_do <= mem[ram_adr];
        for (int b = 0; b < 4; b++)
          if (ram_wren[b]) mem[ram_adr][8*b +: 8] = ram_di[8*b +: 8];
      end
    end
  end

  // Reference model: a grant at edge e owns the RAM in the period after e, answers in
  // the period after e+1, and the next grant can happen no earlier than edge e+3.
  logic        m_cpu_rdy [NP];
  logic        m_dbg_rdy [NP];
  logic        m_cs      [NP];
  logic        m_err     [NP];
  logic        m_rchk    [NP];
  logic [3:0]  m_wren    [NP];
  logic [13:0] m_adr     [NP];
  logic [31:0] m_di      [NP];
  logic [31:0] m_rdata   [NP];
  logic [31:0] shadow    [16384];
  int          m_free;
  logic        m_last, who, hit;
  logic [31:0] a, d;
  logic [3:0]  s;
  logic [13:0] wa;

  initial begin
    for (int i = 0; i < NP; i++) begin
      m_cpu_rdy[i] = 0; m_dbg_rdy[i] = 0; m_cs[i] = 0; m_err[i] = 0; m_rchk[i] = 0;
      m_wren[i] = 0; m_adr[i] = 0; m_di[i] = 0; m_rdata[i] = 0;
    end
    for (int i = 0; i < 16384; i++) shadow[i] = 32'h0;
    m_free = 0;
    m_last = 1'b1;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (cyc >= NP - 2) begin
        $display("FAIL model_range: cycle %0d exceeds model table %0d", cyc, NP);
        $fatal(1);
      end
      if (rst) begin
        m_cpu_rdy[cyc] = 0; m_dbg_rdy[cyc] = 0; m_err[cyc] = 0;
        m_cs[cyc] = 0; m_wren[cyc] = 0; m_rchk[cyc] = 0;
        m_free = cyc + 1;
        m_last = 1'b1;
      end else if (cyc >= m_free && (cpu_valid || dbg_valid)) begin
        who    = (cpu_valid && dbg_valid) ? !m_last : dbg_valid;
        m_last = who;
        a   = who ? dbg_addr : cpu_addr;
        d   = who ? dbg_wdata : cpu_wdata;
        s   = who ? dbg_wstrb : cpu_wstrb;
        hit = (a[17:16] == 2'b10);
        wa  = a[15:2];
        if (hit) begin
          m_cs[cyc] = 1; m_wren[cyc] = s; m_adr[cyc] = wa; m_di[cyc] = d;
        end
        if (who) m_dbg_rdy[cyc+1] = 1;
        else     m_cpu_rdy[cyc+1] = 1;
        m_err[cyc+1] = !hit;
        if (!hit) begin
          m_rchk[cyc+1] = 1; m_rdata[cyc+1] = 32'h0;
        end else if (s == 4'h0) begin
          m_rchk[cyc+1] = 1; m_rdata[cyc+1] = shadow[wa];
        end else begin
          m_rchk[cyc+1] = 0;
          for (int b = 0; b < 4; b++)
            if (s[b]) shadow[wa][8*b +: 8] = d[8*b +: 8];
        end
        m_free = cyc + 3;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-period.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < NP) begin
        chk("cpu_ready", {31'h0, cpu_ready}, {31'h0, m_cpu_rdy[cyc]});
        chk("dbg_ready", {31'h0, dbg_ready}, {31'h0, m_dbg_rdy[cyc]});
        chk("decode_err", {31'h0, decode_err}, {31'h0, m_err[cyc]});
        chk("ram_cs", {31'h0, ram_cs}, {31'h0, m_cs[cyc]});
        chk("ram_wren", {28'h0, ram_wren}, {28'h0, m_wren[cyc]});
        if (m_cs[cyc]) chk("ram_adr", {18'h0, ram_adr}, {18'h0, m_adr[cyc]});
        if (m_cs[cyc] && m_wren[cyc] != 4'h0) chk("ram_di", ram_di, m_di[cyc]);
        if (m_cpu_rdy[cyc]) begin
          if (m_rchk[cyc]) chk("cpu_rdata", cpu_rdata, m_rdata[cyc]);
          chk("dbg_rdata_idle", dbg_rdata, 32'h0);
        end
        if (m_dbg_rdy[cyc]) begin
          if (m_rchk[cyc]) chk("dbg_rdata", dbg_rdata, m_rdata[cyc]);
          chk("cpu_rdata_idle", cpu_rdata, 32'h0);
        end
      end
    end
  end

  task automatic cpu_xfer(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = ad; cpu_wdata = wd; cpu_wstrb = st;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ready && lat < 20);
    chk("cpu_xfer_done", {31'h0, cpu_ready}, 32'h1);
    rd = cpu_rdata; er = decode_err;
    cpu_valid = 1'b0; cpu_wstrb = 4'h0;
  endtask

  task automatic dbg_xfer(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    dbg_valid = 1'b1; dbg_addr = ad; dbg_wdata = wd; dbg_wstrb = st;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dbg_ready && lat < 20);
    chk("dbg_xfer_done", {31'h0, dbg_ready}, 32'h1);
    rd = dbg_rdata; er = decode_err;
    dbg_valid = 1'b0; dbg_wstrb = 4'h0;
  endtask

  logic [31:0] rd, rd2;
  logic        er, er2;
  int          lat, lat2;

  initial begin
    rst = 1'b1;
    cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    dbg_valid = 0; dbg_addr = 0; dbg_wdata = 0; dbg_wstrb = 0;
    repeat (3) @(negedge clk);
    chk("rst_ram_cs", {31'h0, ram_cs}, 32'h0);
    chk("rst_ram_wren", {28'h0, ram_wren}, 32'h0);
    chk("rst_ram_adr", {18'h0, ram_adr}, 32'h0);
    chk("rst_ram_di", ram_di, 32'h0);
    chk("rst_ready", {30'h0, cpu_ready, dbg_ready}, 32'h0);
    chk("rst_rdata", cpu_rdata | dbg_rdata, 32'h0);
    chk("rst_decode_err", {31'h0, decode_err}, 32'h0);
    rst = 1'b0;

    // CPU write then read.
    cpu_xfer(32'h0002_0000, 32'hAABB_CCDD, 4'hF, rd, er, lat);
    chk("wr_latency", lat, 2);
    cpu_xfer(32'h0002_0000, 32'h0, 4'h0, rd, er, lat);
    chk("rd_latency", lat, 2);
    chk("rd_data", rd, 32'hAABB_CCDD);

    // Byte strobes over zeroed word.
    dbg_xfer(32'h0002_0004, 32'h8080_8080, 4'b0101, rd, er, lat);
    cpu_xfer(32'h0002_0004, 32'h0, 4'h0, rd, er, lat);
    chk("strb_data", rd, 32'h0080_0080);

    // Simultaneous requests right after reset: CPU first.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    fork
      cpu_xfer(32'h0002_0000, 32'h0, 4'h0, rd, er, lat);
      dbg_xfer(32'h0002_0004, 32'h0, 4'h0, rd2, er2, lat2);
    join
    chk("tie1_cpu_lat", lat, 2);
    chk("tie1_dbg_lat", lat2, 5);
    chk("tie1_cpu_data", rd, 32'hAABB_CCDD);
    chk("tie1_dbg_data", rd2, 32'h0080_0080);

    // After a CPU grant, a tie goes to DBG.
    cpu_xfer(32'h0002_0000, 32'h0, 4'h0, rd, er, lat);
    fork
      cpu_xfer(32'h0002_0004, 32'h0, 4'h0, rd, er, lat);
      dbg_xfer(32'h0002_0000, 32'h0, 4'h0, rd2, er2, lat2);
    join
    chk("tie2_dbg_lat", lat2, 2);
    chk("tie2_cpu_lat", lat, 5);
    chk("tie2_dbg_data", rd2, 32'hAABB_CCDD);

    // Out-of-window accesses never reach the RAM.
    cpu_xfer(32'h0003_0000, 32'h0, 4'h0, rd, er, lat);
    chk("oow_rdata", rd, 32'h0);
    chk("oow_err", {31'h0, er}, 32'h1);
    cpu_xfer(32'h0003_0000, 32'h1234_5678, 4'hF, rd, er, lat);
    chk("oow_wr_rdata", rd, 32'h0);
    chk("oow_wr_err", {31'h0, er}, 32'h1);
    chk("oow_mem_word0", mem[0], 32'hAABB_CCDD);
    cpu_xfer(32'h0002_0000, 32'h0, 4'h0, rd, er, lat);
    chk("oow_after", rd, 32'hAABB_CCDD);
    chk("inwin_err", {31'h0, er}, 32'h0);

    // Reset during ACCESS of a read: no ready, outputs back to reset values.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h0002_0000; cpu_wstrb = 4'h0;
    @(negedge clk);
    chk("rmid_cs_in_access", {31'h0, ram_cs}, 32'h1);
    rst = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    chk("rmid_no_ready", {31'h0, cpu_ready}, 32'h0);
    chk("rmid_cs", {31'h0, ram_cs}, 32'h0);
    chk("rmid_wren", {28'h0, ram_wren}, 32'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rmid_quiet", {31'h0, cpu_ready}, 32'h0);
    end
    cpu_xfer(32'h0002_0000, 32'h0, 4'h0, rd, er, lat);
    chk("rmid_reissue", rd, 32'hAABB_CCDD);
    chk("rmid_reissue_lat", lat, 2);

    // Reset during ACCESS of a write: the write still lands.
    @(negedge clk);
    dbg_valid = 1'b1; dbg_addr = 32'h0002_0008; dbg_wdata = 32'h1122_3344; dbg_wstrb = 4'hF;
    @(negedge clk);
    chk("wmid_wren_in_access", {28'h0, ram_wren}, 32'hF);
    rst = 1'b1; dbg_valid = 1'b0; dbg_wstrb = 4'h0;
    @(negedge clk);
    chk("wmid_no_ready", {31'h0, dbg_ready}, 32'h0);
    rst = 1'b0;
    cpu_xfer(32'h0002_0008, 32'h0, 4'h0, rd, er, lat);
    chk("wmid_data", rd, 32'h1122_3344);

    // Address wrap: upper bits ignored, top word is 16383.
    cpu_xfer(32'h0002_FFFC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    chk("wrap_mem_top", mem[16383], 32'hCAFE_F00D);
    cpu_xfer(32'h0F02_FFFC, 32'h0, 4'h0, rd, er, lat);
    chk("wrap_alias", rd, 32'hCAFE_F00D);

    // Back-to-back reads with valid held high.
    for (int i = 0; i < 4; i++)
      cpu_xfer(32'h0002_0010 + 32'(4 * i), 32'h0101_0101 * 32'(i + 1), 4'hF, rd, er, lat);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h0002_0010; cpu_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin @(negedge clk); lat++; end while (!cpu_ready && lat < 20);
      chk("b2b_ready", {31'h0, cpu_ready}, 32'h1);
      chk("b2b_data", cpu_rdata, 32'h0101_0101 * 32'(i + 1));
      chk(i == 0 ? "b2b_first_lat" : "b2b_gap", lat, i == 0 ? 2 : 3);
      cpu_addr = cpu_addr + 32'd4;
      if (i == 3) cpu_valid = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter/sequencer in front of the `ram16Kx32` memory, which is selected at `adr[17:16] == 2'b10`. It shares one RAM instance between the PicoRV32 native memory port (CPU) and the UART loader/debug port (DBG). It decodes the address window, sequences each access around the RAM's one-cycle synchronous read, and returns a single-cycle ready pulse to the winning requester. It sits between the CPU/loader and the RAM in the SoC top.

## Interface
Parameters:
- `WIN_SEL`, default `2'b10`: value of `addr[17:16]` that selects the RAM window.
- `ADR_W`, default `14`: RAM word-address width; the RAM address is `addr[ADR_W+1:2]`.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `cpu_valid` in 1: CPU request; held until `cpu_ready`.
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_wstrb` in 4: CPU byte enables; `4'h0` means read.
- `cpu_rdata` out 32: read data; valid only while `cpu_ready` is high.
- `cpu_ready` out 1: one-cycle completion pulse to the CPU.
- `dbg_valid`, `dbg_addr`, `dbg_wdata`, `dbg_wstrb`, `dbg_rdata`, `dbg_ready`: same widths and meanings for the DBG port.
- `ram_cs` out 1: RAM chip select.
- `ram_wren` out 4: RAM byte write enables.
- `ram_adr` out `ADR_W`: RAM word address.
- `ram_di` out 32: RAM write data.
- `ram_do` in 32: RAM read data, valid one edge after `cs` is sampled.
- `decode_err` out 1: pulses together with `*_ready` when the completed request fell outside the window.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If neither valid is high, stay in IDLE.
  - Otherwise, grant per the round-robin rule.
  - Latch the winner's address, wdata and wstrb into registers.
  - Compute `hit = (addr[17:16] == WIN_SEL)`.
  - Go to ACCESS.
- **ACCESS**
  - `ram_cs = hit`.
  - `ram_wren = hit ? wstrb : 4'h0`.
  - `ram_adr` and `ram_di` are taken from the latch.
  - Go to RESP.
- **RESP**
  - Assert the granted port's `ready` for exactly one cycle.
  - Drive the granted port's `rdata = hit ? ram_do : 32'h0`.
  - Set `decode_err = !hit`.
  - `ram_cs = 0`. Go to IDLE.
- **Round-robin rule:** `last_grant` register, 0 = CPU, 1 = DBG.
  - When both valids are high in IDLE, grant the port not equal to `last_grant`.
  - With a single request, grant that port.
  - `last_grant` updates on every grant.
- The non-granted port's `ready` stays 0 and its `rdata` is 0.
- A pending request persists; it is served on the next IDLE, which occurs at most 3 cycles later.
- Writes return `rdata = 32'h0`, except when `hit` and `wstrb != 0` with `ram_do` don't-care: for writes, `rdata` is don't-care and the bench must not check it.
- Requesters deassert valid the edge after ready (PicoRV32 behaviour). A valid still high in IDLE is treated as a new request.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = DBG, so the CPU wins the first tie.
  - `ram_cs = 0`, `ram_wren = 0`, `ram_adr = 0`, `ram_di = 0`.
  - Both `ready` outputs = 0, both `rdata` outputs = 0, `decode_err = 0`.
- Latency: valid sampled high in IDLE at edge k → `ram_cs` high during cycle k+1 → `ready` high during cycle k+2.
- Throughput: one access per 3 cycles.
- Outputs are registered or decoded from the registered state only. There is no combinational path from `*_valid` to `*_ready`.
- Both valids rising on the same edge: one is granted; the other completes exactly 3 cycles after the first ready.
- Reset mid-operation:
  - Reset asserted in ACCESS: the RAM write of that cycle has already been sampled at the same edge and completes.
  - No ready is issued. The FSM is in IDLE with all outputs at reset values after that edge.
- Address wrap: bits above `ADR_W+1` other than `[17:16]` are ignored. `0x2FFFC` maps to word 16383.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, ACCESS, RESP};
  - requester id constants `REQ_CPU = 0`, `REQ_DBG = 1`;
  - `WIN_SEL` and `ADR_W` defaults.
- Sub-module `rr_arbiter2`: 2-input round-robin grant with `last_grant` register and `advance` strobe. Purely the priority logic; the FSM and datapath stay in `mem_arbiter`.

## Test plan
- **CPU write then read:** CPU writes `0xAABBCCDD` to `0x20000` with `wstrb F`, then reads it back. Required: `cpu_ready` 2 cycles after each valid edge, `cpu_rdata = 0xAABBCCDD`.
- **Byte strobe:** DBG writes `0x80808080` to `0x20004` with `wstrb 4'b0101`, over prior contents `0x00000000`. A CPU read of `0x20004` returns `0x00800080`.
- **Simultaneous requests after reset:** CPU and DBG both request on the same edge. Required: CPU ready at cycle k+2, DBG ready at k+5. Repeat with both requesting: DBG is served first.
- **Out-of-window access:** CPU reads `0x30000`. Required: `ram_cs` never asserted, `cpu_ready` with `cpu_rdata = 0` and `decode_err = 1`. RAM contents unchanged.
- **Reset mid-operation:** assert `rst` for one cycle while in ACCESS for a read. Required: no `cpu_ready` pulse; next cycle `ram_cs = 0`, `ram_wren = 0`, FSM in IDLE. A re-issued read then completes normally.
- **Back-to-back:** CPU keeps valid high across 4 reads. Required: ready every 3 cycles and correct data for each address, with no dropped or duplicated pulse.
